ram_upload: RTL and testbench

Streams main-RAM contents from SDRAM back to the HPS over the ioctl upload handshake, so memory images can be saved. It is the reverse path of the boot/expansion ROM download loader. It sits beside that loader in the top level and owns the SDRAM request port while `ioctl_upload` is high. It hides SDRAM latency with a one-byte sequential prefetch.

---
 rtl/upload_pkg.sv | 19 +
 rtl/ce_slot_counter.sv | 30 +++
 rtl/ram_upload.sv | 205 ++++++++++++++++++++
 tb/tb_ram_upload.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/upload_pkg.sv
// Shared types for the SDRAM upload/download loaders: FSM states, read kinds
// and the fill byte returned for offsets beyond the image.
package upload_pkg;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_LAT,
      S_CAPTURE
   } state_t;

   typedef enum logic {
      K_DEMAND,
      K_PREFETCH
   } kind_t;

   localparam logic [7:0] OOR_FILL = 8'hFF;

endpackage

// File: rtl/ce_slot_counter.sv
// Counts ce_ref strobes while run is high and flags the RD_LAT-th one.
// Reloads whenever run is low, so each read starts a fresh count.
module ce_slot_counter #(
   parameter int RD_LAT = 1
) (
   input  logic clk_sys,
   input  logic reset,
   input  logic ce_ref,
   input  logic run,
   output logic done
);

   localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
   localparam logic [CW-1:0] LOAD = CW'(RD_LAT - 1);

   logic [CW-1:0] cnt_q;

   assign done = run && ce_ref && (cnt_q == '0);

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         cnt_q <= LOAD;
      end else if (!run) begin
         cnt_q <= LOAD;
      end else if (ce_ref && (cnt_q != '0)) begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

endmodule

// File: rtl/ram_upload.sv
// Streams main RAM from SDRAM to the HPS over the ioctl upload handshake,
// hiding SDRAM latency with a one-byte sequential prefetch.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   S_IDLE    | no read pending
//   S_ISSUE   | mem_rd high, waiting for ce_ref to sample it
//   S_LAT     | request sampled, counting RD_LAT ce_ref strobes
//   S_CAPTURE | mem_dout valid this cycle
module ram_upload
   import upload_pkg::*;
#(
   parameter int          SIZE   = 131072,
   parameter int          RD_LAT = 1,
   parameter logic [22:0] BASE   = 23'h000000
) (
   input  logic        clk_sys,
   input  logic        reset,
   input  logic        ce_ref,
   input  logic        ioctl_upload,
   input  logic        ioctl_rd,
   input  logic [24:0] ioctl_addr,
   output logic [7:0]  ioctl_din,
   output logic        ioctl_wait,
   output logic        mem_rd,
   output logic [22:0] mem_addr,
   output logic [1:0]  mem_bank,
   input  logic        model,
   input  logic [7:0]  mem_dout,
   output logic        busy
);

   localparam logic [22:0] SIZE_L = 23'(SIZE);

   state_t      state_q, state_d;
   kind_t       kind_q, kind_d;
   logic [21:0] rd_off_q, rd_off_d;
   logic        discard_q, discard_d;
   logic        drain_q, drain_d;
   logic        pf_valid_q, pf_valid_d;
   logic [21:0] pf_off_q, pf_off_d;
   logic [7:0]  pf_data_q, pf_data_d;
   logic [7:0]  din_q, din_d;
   logic        wait_q, wait_d;
   logic        busy_q, busy_d;
   logic        upload_q;
   logic        bank_q;

   logic [21:0] off;
   logic        unused_addr_hi;
   logic        rd_acc, up_rise, up_fall, oor, in_flight, pf_track;
   logic        slot_run, slot_done;
   logic        launch;
   logic [21:0] launch_off;

   assign off            = ioctl_addr[21:0];
   assign unused_addr_hi = ^ioctl_addr[24:22];
   assign rd_acc         = ioctl_rd && ioctl_upload && !wait_q;
   assign up_rise        = ioctl_upload && !upload_q;
   assign up_fall        = !ioctl_upload && upload_q;
   assign oor            = ({1'b0, off} >= SIZE_L);
   // A request in ISSUE is already committed if ce_ref samples it this cycle.
   assign in_flight      = (state_q == S_LAT) || ((state_q == S_ISSUE) && ce_ref);
   assign pf_track       = (kind_q == K_PREFETCH) && !discard_q && (rd_off_q == off);
   assign slot_run       = (state_q == S_LAT) || drain_q;

   ce_slot_counter #(.RD_LAT(RD_LAT)) u_slot (
      .clk_sys (clk_sys),
      .reset   (reset),
      .ce_ref  (ce_ref),
      .run     (slot_run),
      .done    (slot_done)
   );

   always_comb begin
      state_d    = state_q;
      kind_d     = kind_q;
      rd_off_d   = rd_off_q;
      discard_d  = discard_q;
      pf_valid_d = pf_valid_q;
      pf_off_d   = pf_off_q;
      pf_data_d  = pf_data_q;
      din_d      = din_q;
      wait_d     = wait_q;
      launch     = 1'b0;
      launch_off = rd_off_q;

      case (state_q)
         S_ISSUE: if (ce_ref) state_d = S_LAT;
         S_LAT:   if (slot_done) state_d = S_CAPTURE;
         S_CAPTURE: begin
            if (discard_q) begin
               state_d   = S_ISSUE;
               discard_d = 1'b0;
            end else if (kind_q == K_DEMAND) begin
               din_d  = mem_dout;
               wait_d = 1'b0;
               launch = 1'b1;
            end else begin
               pf_data_d  = mem_dout;
               pf_off_d   = rd_off_q;
               pf_valid_d = 1'b1;
               state_d    = S_IDLE;
            end
         end
         default: ;
      endcase

      if (rd_acc) begin
         if (oor) begin
            din_d = OOR_FILL;
         end else if ((state_q == S_CAPTURE) && pf_track) begin
            din_d      = mem_dout;
            pf_valid_d = 1'b0;
            launch     = 1'b1;
            launch_off = off;
         end else if (pf_valid_q && (pf_off_q == off)) begin
            din_d      = pf_data_q;
            pf_valid_d = 1'b0;
            launch     = 1'b1;
            launch_off = off;
         end else if (((state_q == S_ISSUE) || (state_q == S_LAT)) && pf_track) begin
            kind_d = K_DEMAND;
            wait_d = 1'b1;
         end else begin
            wait_d     = 1'b1;
            pf_valid_d = 1'b0;
            rd_off_d   = off;
            kind_d     = K_DEMAND;
            // SDRAM reads cannot be cancelled: let a committed one finish first.
            if (in_flight) begin
               discard_d = 1'b1;
            end else begin
               state_d   = S_ISSUE;
               discard_d = 1'b0;
            end
         end
      end

      if (launch) begin
         if (({1'b0, launch_off} + 23'd1) < SIZE_L) begin
            state_d   = S_ISSUE;
            kind_d    = K_PREFETCH;
            rd_off_d  = launch_off + 22'd1;
            discard_d = 1'b0;
         end else begin
            state_d = S_IDLE;
         end
      end

      if (up_rise) pf_valid_d = 1'b0;

      drain_d = drain_q && !slot_done;
      if (up_fall) begin
         state_d    = S_IDLE;
         wait_d     = 1'b0;
         pf_valid_d = 1'b0;
         discard_d  = 1'b0;
         drain_d    = drain_d || ((state_q == S_LAT) && !slot_done)
                              || ((state_q == S_ISSUE) && ce_ref);
      end

      busy_d = ioctl_upload || (state_d != S_IDLE) || drain_d;
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         kind_q     <= K_DEMAND;
         rd_off_q   <= '0;
         discard_q  <= 1'b0;
         drain_q    <= 1'b0;
         pf_valid_q <= 1'b0;
         pf_off_q   <= '0;
         pf_data_q  <= '0;
         din_q      <= OOR_FILL;
         wait_q     <= 1'b0;
         busy_q     <= 1'b0;
         upload_q   <= 1'b0;
         bank_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         kind_q     <= kind_d;
         rd_off_q   <= rd_off_d;
         discard_q  <= discard_d;
         drain_q    <= drain_d;
         pf_valid_q <= pf_valid_d;
         pf_off_q   <= pf_off_d;
         pf_data_q  <= pf_data_d;
         din_q      <= din_d;
         wait_q     <= wait_d;
         busy_q     <= busy_d;
         upload_q   <= ioctl_upload;
         if (up_rise) bank_q <= model;
      end
   end

   assign ioctl_din  = din_q;
   assign ioctl_wait = wait_q;
   assign mem_rd     = (state_q == S_ISSUE);
   assign mem_addr   = BASE + {1'b0, rd_off_q};
   assign mem_bank   = {1'b0, bank_q};
   assign busy       = busy_q;

endmodule

// File: tb/tb_ram_upload.sv
// Directed bench for ram_upload: SDRAM model returns offset ^ 8'hA5 one
// ce_ref slot after sampling a request.
module tb_ram_upload;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        ce_ref;
   logic        ioctl_upload;
   logic        ioctl_rd;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_din;
   logic        ioctl_wait;
   logic        mem_rd;
   logic [22:0] mem_addr;
   logic [1:0]  mem_bank;
   logic        model;
   logic [7:0]  mem_dout = 8'h00;
   logic        busy;

   int errors = 0;
   int checks = 0;

   logic [3:0]  ce_cnt = 4'd0;
   logic        lat_v = 1'b0;
   logic [7:0]  lat_addr = 8'h00;
   int          rd_count = 0;

   always #5 clk_sys = ~clk_sys;

   assign ce_ref = (ce_cnt == 4'd15);

   always @(posedge clk_sys) begin
      ce_cnt <= ce_cnt + 4'd1;
      if (ce_ref) begin
         if (lat_v) mem_dout <= lat_addr ^ 8'hA5;
         lat_v    <= mem_rd;
         lat_addr <= mem_addr[7:0];
         if (mem_rd) rd_count <= rd_count + 1;
      end
   end

   ram_upload #(.SIZE(16), .RD_LAT(1), .BASE(23'h000000)) dut (
      .clk_sys      (clk_sys),
      .reset        (reset),
      .ce_ref       (ce_ref),
      .ioctl_upload (ioctl_upload),
      .ioctl_rd     (ioctl_rd),
      .ioctl_addr   (ioctl_addr),
      .ioctl_din    (ioctl_din),
      .ioctl_wait   (ioctl_wait),
      .mem_rd       (mem_rd),
      .mem_addr     (mem_addr),
      .mem_bank     (mem_bank),
      .model        (model),
      .mem_dout     (mem_dout),
      .busy         (busy)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_rd(input int off);
      @(negedge clk_sys);
      ioctl_rd   = 1'b1;
      ioctl_addr = 25'(off);
      @(negedge clk_sys);
      ioctl_rd   = 1'b0;
   endtask

   task automatic wait_low(output int wc);
      wc = 0;
      while (ioctl_wait === 1'b1 && wc < 100) begin
         @(negedge clk_sys);
         wc++;
      end
   endtask

   task automatic wait_mem_rd(input logic val, input string tag);
      int n = 0;
      while (mem_rd !== val && n < 40) begin
         @(negedge clk_sys);
         n++;
      end
      check(tag, {31'd0, mem_rd}, {31'd0, val});
   endtask

   initial begin
      int wc;
      int rc;
      ioctl_upload = 1'b0;
      ioctl_rd     = 1'b0;
      ioctl_addr   = '0;
      model        = 1'b1;
      reset        = 1'b1;

      repeat (3) @(negedge clk_sys);
      check("rst_din",  32'(ioctl_din),  32'hFF);
      check("rst_wait", 32'(ioctl_wait), 32'd0);
      check("rst_mrd",  32'(mem_rd),     32'd0);
      check("rst_busy", 32'(busy),       32'd0);
      check("rst_addr", 32'(mem_addr),   32'd0);
      check("rst_bank", 32'(mem_bank),   32'd0);

      reset = 1'b0;
      @(negedge clk_sys);
      ioctl_upload = 1'b1;
      repeat (3) @(negedge clk_sys);
      check("start_bank", 32'(mem_bank), 32'd1);
      check("start_busy", 32'(busy),     32'd1);

      // single demand read
      pulse_rd(5);
      check("miss5_wait", 32'(ioctl_wait), 32'd1);
      check("miss5_mrd",  32'(mem_rd),     32'd1);
      check("miss5_addr", 32'(mem_addr),   32'd5);
      wait_low(wc);
      check("miss5_lat",  32'(wc > 0 && wc <= 34), 32'd1);
      check("miss5_din",  32'(ioctl_din), 32'hA0);
      repeat (40) @(negedge clk_sys);

      // sequential stream: everything after offset 0 is a prefetch hit
      for (int k = 0; k < 16; k++) begin
         pulse_rd(k);
         wait_low(wc);
         check("seq_din", 32'(ioctl_din), 32'(k[7:0] ^ 8'hA5));
         if (k == 0) check("seq_miss0", 32'(wc > 0 && wc <= 34), 32'd1);
         else        check("seq_nowait", 32'(wc), 32'd0);
         if (k < 15) repeat (40) @(negedge clk_sys);
      end
      rc = rd_count;
      check("seq_end_mrd", 32'(mem_rd), 32'd0);
      repeat (60) @(negedge clk_sys);
      check("seq_no_read", 32'(rd_count - rc), 32'd0);

      // out of range
      pulse_rd(16);
      check("oor_din",  32'(ioctl_din),  32'hFF);
      check("oor_wait", 32'(ioctl_wait), 32'd0);
      check("oor_mrd",  32'(mem_rd),     32'd0);

      // non-sequential read while the prefetch of 4 is in flight
      pulse_rd(3);
      wait_low(wc);
      check("ns3_din", 32'(ioctl_din), 32'hA6);
      rc = rd_count;
      wait_mem_rd(1'b1, "ns_pf_issue");
      wait_mem_rd(1'b0, "ns_pf_sampled");
      pulse_rd(9);
      check("ns9_wait", 32'(ioctl_wait), 32'd1);
      wait_low(wc);
      check("ns9_din",   32'(ioctl_din), 32'hAC);
      check("ns_nreads", 32'(rd_count - rc), 32'd2);

      // upload end while the prefetch of 10 sits in ISSUE
      check("end_pre_mrd", 32'(mem_rd), 32'd1);
      ioctl_upload = 1'b0;
      @(negedge clk_sys);
      check("end_mrd",  32'(mem_rd),     32'd0);
      check("end_wait", 32'(ioctl_wait), 32'd0);
      check("end_busy", 32'(busy),       32'd0);

      // asynchronous reset while a demand read is in LAT
      ioctl_upload = 1'b1;
      repeat (2) @(negedge clk_sys);
      pulse_rd(7);
      wait_mem_rd(1'b0, "lat_sampled");
      check("lat_wait", 32'(ioctl_wait), 32'd1);
      #2 reset = 1'b1;
      #1;
      check("mid_din",  32'(ioctl_din),  32'hFF);
      check("mid_wait", 32'(ioctl_wait), 32'd0);
      check("mid_mrd",  32'(mem_rd),     32'd0);
      check("mid_busy", 32'(busy),       32'd0);
      check("mid_addr", 32'(mem_addr),   32'd0);
      check("mid_bank", 32'(mem_bank),   32'd0);
      @(negedge clk_sys);
      reset = 1'b0;
      repeat (2) @(negedge clk_sys);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
